// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared types and constants for the multiply/divide unit:
//               operation encoding, FSM states, default operand width and
//               the ALU opcodes that decode into this unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // Default operand width; HI and LO are each this wide.
    localparam int C_MDU_WIDTH = 32;

    // ALU operation codes handed over to the multi-cycle unit by decode.
    localparam logic [4:0] C_ALU_OP_MULT = 5'h0F;
    localparam logic [4:0] C_ALU_OP_DIV  = 5'h10;

    // Operation select; bit 1 = divide, bit 0 = unsigned.
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_e;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Multi-cycle integer multiply/divide unit with architectural
//               HI/LO registers. Radix-2 shift-add multiply and restoring
//               shift-subtract divide share one 2*WIDTH+1 working register;
//               signed operations run on magnitudes and are sign-fixed at
//               the end.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = C_MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    mdu_state_e           r_state;
    mdu_state_e           w_state_next;
    mdu_op_e              r_op;
    logic [2*WIDTH:0]     r_acc;     // shared working register
    logic [WIDTH-1:0]     r_b;       // multiplicand / divisor magnitude
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg_q;   // negate product or quotient
    logic                 r_neg_r;   // negate remainder (dividend sign)
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic                 r_dbz;

    // ------------------------------------------------------------------
    // Operand conditioning at launch
    // ------------------------------------------------------------------
    logic                 w_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_launch;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & op_a[WIDTH-1];
    assign w_b_neg  = w_signed & op_b[WIDTH-1];
    // The most negative value maps to itself, which is its correct
    // unsigned magnitude.
    assign w_a_mag  = w_a_neg ? -op_a : op_a;
    assign w_b_mag  = w_b_neg ? -op_b : op_b;
    // A flush in the same cycle kills the launch.
    assign w_launch = start & ~flush;

    // ------------------------------------------------------------------
    // One multiply iteration: add multiplicand if LSB set, shift right.
    // ------------------------------------------------------------------
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH:0]     w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // One restoring divide iteration: shift left, trial subtract, keep
    // the difference only when it is non-negative.
    // ------------------------------------------------------------------
    logic [2*WIDTH:0]     w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH:0]     w_div_next;

    assign w_div_shift = {r_acc[2*WIDTH-1:0], 1'b0};
    assign w_div_diff  = w_div_shift[2*WIDTH:WIDTH] - {1'b0, r_b};
    assign w_div_next  = w_div_diff[WIDTH]
                       ? w_div_shift
                       : {w_div_diff, w_div_shift[WIDTH-1:1], 1'b1};

    // Top bit only carries intermediate overflow inside an iteration.
    logic                 w_unused_acc_top;
    assign w_unused_acc_top = r_acc[2*WIDTH];

    // ------------------------------------------------------------------
    // Sign correction of the finished result
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    assign w_prod     = r_acc[2*WIDTH-1:0];
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0]       : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic                 w_fix_commit;
    logic                 w_dbz_hit;

    // Next-state and result-commit decode.
    always_comb begin
        w_state_next = r_state;
        w_fix_commit = 1'b0;
        w_dbz_hit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == C_CNT_ONE) begin
                    w_state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_state_next = ST_IDLE;
                w_fix_commit = ~flush;
                w_dbz_hit    = ~flush & r_op[1] & (r_b == {WIDTH{1'b0}});
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath, HI/LO and registered status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op    <= OP_MULT;
            r_acc   <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= w_fix_commit;
            r_dbz  <= w_dbz_hit;
            case (r_state)
                ST_IDLE: begin
                    if (hi_we) begin
                        r_hi <= wdata;
                    end
                    if (lo_we) begin
                        r_lo <= wdata;
                    end
                    if (w_launch) begin
                        r_op    <= mdu_op_e'(op);
                        r_b     <= w_b_mag;
                        r_acc   <= {{(WIDTH+1){1'b0}}, w_a_mag};
                        r_cnt   <= C_CNT_INIT;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        r_cnt <= '0;
                    end else begin
                        r_acc <= r_op[1] ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt - C_CNT_ONE;
                    end
                end
                ST_FIX: begin
                    if (w_fix_commit) begin
                        if (!r_op[1]) begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end else if (!w_dbz_hit) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule : mul_div_unit
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Scoreboard bench for mul_div_unit. Directed operations push
//               hand-computed HI/LO/div_by_zero into a queue; a monitor pops
//               and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    mul_div_unit #(.WIDTH(WIDTH)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .op_a        (op_a),
        .op_b        (op_b),
        .flush       (flush),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Pops one expected result per done pulse and checks the status pulses.
    task automatic monitor();
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done) begin
                chk("done_not_consecutive", {63'b0, prev_done}, 64'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", {63'b0, done}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_hi"},  {32'b0, hi}, {32'b0, e.hi});
                    chk({e.name, "_lo"},  {32'b0, lo}, {32'b0, e.lo});
                    chk({e.name, "_dbz"}, {63'b0, div_by_zero}, {63'b0, e.dbz});
                    chk({e.name, "_busy_low"}, {63'b0, busy}, 64'd0);
                end
            end else if (div_by_zero) begin
                chk("dbz_without_done", {63'b0, div_by_zero}, 64'd0);
            end
            prev_done = done;
        end
    endtask

    // Drives start for one edge; optionally records the expected result.
    task automatic launch(input string name, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz, input bit push);
        exp_t e;
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        if (push) begin
            e.name = name;
            e.hi   = ehi;
            e.lo   = elo;
            e.dbz  = edbz;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done; lat counts cycles after the start edge.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        if (!done) chk("done_timeout", {63'b0, done}, 64'd1);
    endtask

    int lat;
    int bcnt;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        op_a  = '0;
        op_b  = '0;
        flush = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi",   {32'b0, hi}, 64'd0);
        chk("reset_lo",   {32'b0, lo}, 64'd0);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_dbz",  {63'b0, div_by_zero}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MULT -2 * 3 with latency and busy-length checks
        launch("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b1);
        wait_done(lat, bcnt);
        chk("mult_latency",   lat,  64'd34);
        chk("mult_busy_cycles", bcnt, 64'd33);

        // MULTU max * max, then DIVU launched in the done cycle
        @(negedge clk);
        launch("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
        wait_done(lat, bcnt);
        launch("divu_100_7", 2'b11, 32'd100, 32'd7,
               32'h0000_0002, 32'h0000_000E, 1'b0, 1'b1);
        wait_done(lat, bcnt);
        chk("b2b_latency", lat, 64'd34);

        // DIV -7 / 2 truncates toward zero
        @(negedge clk);
        launch("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
        wait_done(lat, bcnt);

        // Preload HI/LO, then divide by zero; mthi while busy is ignored
        @(posedge clk); #1;
        hi_we = 1'b1; wdata = 32'h11;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        @(posedge clk); #1;
        lo_we = 1'b0;
        chk("mthi_idle", {32'b0, hi}, 64'h11);
        chk("mtlo_idle", {32'b0, lo}, 64'h22);
        launch("divu_by_zero", 2'b11, 32'd5, 32'd0,
               32'h0000_0011, 32'h0000_0022, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        hi_we = 1'b1; wdata = 32'h99;
        @(posedge clk); #1;
        hi_we = 1'b0;
        wait_done(lat, bcnt);

        // DIV min / -1 with an ignored second start while busy
        @(negedge clk);
        launch("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = 2'b01; op_a = 32'd1; op_b = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        repeat (40) @(negedge clk);

        // mthi together with start: result overwrites the write
        @(posedge clk); #1;
        hi_we = 1'b1; wdata = 32'h55;
        launch("mult_7_m3", 2'b00, 32'd7, 32'hFFFF_FFFD,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
        hi_we = 1'b0;
        wait_done(lat, bcnt);

        // Flush 10 cycles after start: no done, HI/LO kept
        @(negedge clk);
        launch("flushed", 2'b01, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {63'b0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        chk("flush_hi", {32'b0, hi}, 64'hFFFF_FFFF);
        chk("flush_lo", {32'b0, lo}, 64'hFFFF_FFEB);

        // flush and start together in IDLE: start ignored
        @(posedge clk); #1;
        flush = 1'b1;
        launch("flush_start", 2'b01, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0);
        flush = 1'b0;
        chk("flush_start_busy", {63'b0, busy}, 64'd0);

        // Reset mid-operation
        @(negedge clk);
        launch("reset_mid", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_hi",   {32'b0, hi}, 64'd0);
        chk("rstmid_lo",   {32'b0, lo}, 64'd0);
        chk("rstmid_busy", {63'b0, busy}, 64'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        chk("scoreboard_drained", sb.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mul_div_unit
`default_nettype wire

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle integer multiply/divide unit with architectural HI/LO registers, placed in the EX stage beside the ALU. It takes over ALU operations 0xF (multiply) and 0x10 (divide) so those no longer need a single-cycle combinational path. Operands come from the ID/EX register (rs, rt). Results stay in HI/LO, where mfhi/mflo read them. While the unit is busy, the hazard unit stalls the pipeline.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- op_a  in  WIDTH  rs (multiplicand / dividend).
- op_b  in  WIDTH  rt (multiplier / divisor).
- flush  in  1  abort the operation in flight.
- hi_we, lo_we  in  1 each  mthi/mtlo write enables.
- wdata  in  WIDTH  mthi/mtlo data.
- busy  out  1  operation in progress; drives the stall.
- done  out  1  one-cycle pulse; HI/LO hold the result in this cycle.
- div_by_zero  out  1  pulses with done when DIV/DIVU had op_b==0.
- hi, lo  out  WIDTH  architectural HI/LO register contents.

## Operation
- Reset: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0.
- States:
  - IDLE: start=1 latches op, the operand magnitudes (signed ops take abs values) and the result sign flags, then moves to CALC.
  - CALC: WIDTH iterations, one per cycle.
    - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract; the remainder is in the upper half, the quotient in the lower half.
    - When the counter reaches 0, move to FIX.
  - FIX: apply sign correction, write HI/LO, assert done for one cycle, return to IDLE.
- Arithmetic rules:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product.
  - DIV/DIVU: lo=quotient, hi=remainder.
  - Signed divide truncates toward zero; the remainder takes the dividend's sign.
  - DIV 0x80000000 / -1: lo=0x80000000, hi=0. No trap, no flag.
  - Divisor 0: the iteration still runs. In FIX, HI/LO are not written, div_by_zero=1 with done.
- mthi/mtlo:
  - In IDLE: write at the edge.
  - While busy: ignored. The hazard unit never issues them while busy.
  - Same cycle as start in IDLE: the write takes effect, then the result overwrites it at FIX.
- Boundary conditions:
  - start while busy: ignored, with no queuing.
  - flush in CALC or FIX: next state IDLE, busy=0 next cycle, no done, HI/LO unchanged.
  - flush and start together in IDLE: start is ignored.
  - rst_n low mid-operation: full reset at that edge, with no result write.

## Timing
- Start sampled at edge E0.
- busy=1 for cycles E0+1 through E0+WIDTH+1: WIDTH CALC cycles plus 1 FIX cycle.
- At edge E0+WIDTH+2: HI/LO updated, done=1 and busy=0 in that cycle. Latency is 34 cycles for WIDTH=32.
- done and div_by_zero are registered outputs and are never high for two consecutive cycles.
- A new start is accepted in the same cycle done is high; the unit is in IDLE then.
- Back-to-back throughput is one operation per WIDTH+2 cycles.

## Structure
- Package mdu_pkg:
  - op encoding enum (MULT, MULTU, DIV, DIVU);
  - state enum (IDLE, CALC, FIX);
  - default WIDTH constant;
  - ALU opcodes 0xF/0x10 for the decode mapping.
- Datapath: one shared 2*WIDTH+1-bit working register plus a $clog2(WIDTH+1) counter.
- No sub-module; abs/negate logic is inline.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003: done at E0+34, hi=0xFFFFFFFF, lo=0xFFFFFFFA. busy is high exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
- DIV −7/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7: lo=0x0000000E, hi=0x00000002.
- Divide by zero: preload with mthi 0x11, mtlo 0x22, then DIVU 5/0. Required: done with div_by_zero=1, hi=0x11, lo=0x22.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. A second start issued during this op is ignored.
- Flush and reset mid-operation:
  - flush 10 cycles after start: busy=0 next cycle, no done, HI/LO unchanged.
  - rst_n low mid-operation: hi=lo=0, busy=0 after the edge.
